// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult_param sequential multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  function automatic bit width_legal(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/seq_mult_param_twos_neg.sv
// Parametrised two's-complement negator (~x + 1), purely combinational.
module mult_twos_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign y = ~x + ONE;

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, signed/unsigned per operation, one iteration per clock.
// Optional early exit on exhausted multiplier bits: define SEQ_MULT_ZERO_SKIP_EN.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               abort,
  output logic               ready,
  output logic [2*WIDTH-1:0] prodt,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int              PW       = 2 * WIDTH;
  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("seq_mult_param: WIDTH must lie in 4..64");
  end

  state_t             state_r;
  logic [PW-1:0]      h_r;
  logic [WIDTH-1:0]   q_r;
  logic [PW-1:0]      acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r;
  logic [PW-1:0]      prodt_r;
  logic               out_valid_r;

  logic [WIDTH-1:0]   mlier_neg_s;
  logic [WIDTH-1:0]   mcand_neg_s;
  logic [PW-1:0]      acc_neg_s;
  logic [WIDTH-1:0]   mlier_mag_s;
  logic [WIDTH-1:0]   mcand_mag_s;
  logic               last_iter_s;

  mult_twos_neg #(.W(WIDTH)) u_neg_mlier (.x(mlier), .y(mlier_neg_s));
  mult_twos_neg #(.W(WIDTH)) u_neg_mcand (.x(mcand), .y(mcand_neg_s));
  mult_twos_neg #(.W(PW))    u_neg_acc   (.x(acc_r), .y(acc_neg_s));

  // Most-negative input negates to itself; its unsigned reading is the correct magnitude.
  assign mlier_mag_s = (is_signed && mlier[WIDTH-1]) ? mlier_neg_s : mlier;
  assign mcand_mag_s = (is_signed && mcand[WIDTH-1]) ? mcand_neg_s : mcand;

  assign ready     = (state_r == IDLE);
  assign prodt     = prodt_r;
  assign out_valid = out_valid_r;

  // Decide whether the current RUN iteration is the final one.
  always_comb begin
    last_iter_s = 1'b0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
    if ((cnt_r == CNT_LAST) || (q_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
      last_iter_s = 1'b1;
    end else begin
      last_iter_s = 1'b0;
    end
`else
    if (cnt_r == CNT_LAST) begin
      last_iter_s = 1'b1;
    end else begin
      last_iter_s = 1'b0;
    end
`endif
  end

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      h_r         <= {PW{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      acc_r       <= {PW{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      neg_r       <= 1'b0;
      prodt_r     <= {PW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            h_r     <= {{WIDTH{1'b0}}, mcand_mag_s};
            q_r     <= mlier_mag_s;
            neg_r   <= is_signed & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            if (q_r[0]) begin
              acc_r <= acc_r + h_r;
            end
            h_r   <= {h_r[PW-2:0], 1'b0};
            q_r   <= {1'b0, q_r[WIDTH-1:1]};
            cnt_r <= cnt_r + CNT_ONE;
            if (last_iter_s) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          if (abort) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            prodt_r     <= neg_r ? acc_neg_s : acc_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard-driven directed bench for seq_mult_param at WIDTH=32.
module tb_seq_mult_param;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   mlier;
  logic [W-1:0]   mcand;
  logic           abort;
  logic           ready;
  logic [2*W-1:0] prodt;
  logic           out_valid;
  logic           out_ready;

  seq_mult_param #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .mlier     (mlier),
    .mcand     (mcand),
    .abort     (abort),
    .ready     (ready),
    .prodt     (prodt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] p;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [63:0] exp_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb_v;
    if (s) begin
      sa   = {{32{a[31]}}, a};
      sb_v = {{32{b[31]}}, b};
      return sa * sb_v;
    end else begin
      return {32'h0, a} * {32'h0, b};
    end
  endfunction

  function automatic logic [31:0] exp_lat(input logic s, input logic [31:0] a);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic [31:0] mag;
    int k;
    mag = (s && a[31]) ? (32'd0 - a) : a;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i;
    return 32'(k + 2);
`else
    return 32'(W + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    int guard = 0;
    @(negedge clock);
    while (!ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    chk("issue_ready", {63'd0, ready}, 64'd1);
    start = 1'b1; is_signed = s; mlier = a; mcand = b;
    if (push) sb.push_back({exp_prod(s, a, b), exp_lat(s, a)});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic collect(output logic [63:0] got);
    int   cyc = 0;
    exp_t e;
    chk("ready_low_busy", {63'd0, ready}, 64'd0);
    while (!out_valid && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    got = prodt;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("prodt", prodt, e.p);
      chk("latency", 64'(cyc), {32'd0, e.lat});
      chk("ready_in_done", {63'd0, ready}, 64'd0);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("valid_cleared", {63'd0, out_valid}, 64'd0);
    chk("ready_after_consume", {63'd0, ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] prev;
    int          seen;

    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; abort = 1'b0;
    out_ready = 1'b0; mlier = '0; mcand = '0;
    #2;
    chk("reset_prodt", prodt, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    issue(1'b1, 32'hFFFFFFFD, 32'd7, 1'b1); collect(got);
    chk("plan_m3x7", got, 64'hFFFFFFFF_FFFFFFEB); consume();
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); collect(got);
    chk("plan_umax_sq", got, 64'hFFFFFFFE_00000001); consume();
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); collect(got);
    chk("plan_m1_sq", got, 64'd1); consume();
    issue(1'b1, 32'h80000000, 32'h80000000, 1'b1); collect(got);
    chk("plan_min_sq", got, 64'h40000000_00000000); consume();
    issue(1'b1, 32'h80000000, 32'd1, 1'b1); collect(got);
    chk("plan_min_x1", got, 64'hFFFFFFFF_80000000); consume();
    issue(1'b0, 32'd1, 32'd5, 1'b1); collect(got);
    chk("plan_1x5", got, 64'd5); consume();
    issue(1'b0, 32'd0, 32'hABCDEF01, 1'b1); collect(got);
    chk("plan_zero", got, 64'd0); consume();
    issue(1'b0, 32'h00010000, 32'd3, 1'b1); collect(got); consume();
    issue(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1); collect(got); consume();

    for (int i = 0; i < 6; i++) begin
      issue(1'(i % 2), $urandom, $urandom, 1'b1);
      collect(got);
      consume();
    end

    // Back-pressure: result must hold and a start pulse must be dropped.
    issue(1'b0, 32'h00001234, 32'h00005678, 1'b1); collect(got);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      mlier = 32'h0000_0009; mcand = 32'h0000_0009;
      @(negedge clock);
      chk("hold_prodt", prodt, got);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_ready", {63'd0, ready}, 64'd0);
    end
    start = 1'b0;
    consume();
    @(negedge clock);
    chk("start_not_queued", {63'd0, ready}, 64'd1);

    // abort together with start in IDLE: nothing starts.
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {63'd0, ready}, 64'd1);

    // abort during RUN.
    prev = prodt;
    issue(1'b0, 32'h40000011, 32'h00000022, 1'b0);
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_prodt", prodt, prev);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of RUN.
    issue(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_prodt", prodt, 64'd0);
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_ready", {63'd0, ready}, 64'd1);
    @(negedge clock);
    reset_n = 1'b1;

    issue(1'b1, 32'hFFFFFF00, 32'h00000100, 1'b1); collect(got); consume();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier. Handles signed and unsigned operands, selected per operation, and returns a full 2·WIDTH-bit product. Operation is one add/shift iteration per clock, with a start/ready input handshake, an out_valid/out_ready result handshake and an abort. It is the multi-cycle multiply unit for datapaths that trade latency for area.

## Interface
- WIDTH, default 32: operand width; legal values 4..64. Product width is 2·WIDTH.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on an edge where ready=1.
- is_signed  in  1  sampled with start; 1 = two's-complement operands, 0 = unsigned.
- mlier  in  WIDTH  multiplier; sampled with start.
- mcand  in  WIDTH  multiplicand; sampled with start.
- abort  in  1  cancels any operation in progress.
- ready  out  1  high when state is IDLE; combinational from state.
- prodt  out  2·WIDTH  registered product; held until overwritten.
- out_valid  out  1  product available; registered.
- out_ready  in  1  consumer accepts the product.

## Operation
- FSM states: IDLE, RUN, FIX, DONE. Reset state is IDLE.
- Reset values: prodt=0, out_valid=0, ready=1, all internal registers 0.
- IDLE:
  - On start & ready & !abort, capture operands.
    - h = |mcand| zero-extended to 2·WIDTH.
    - q = |mlier|.
    - neg = is_signed & (mlier[MSB] ^ mcand[MSB]).
    - acc = 0, cnt = 0.
  - Then go to RUN.
  - Magnitude is taken only when is_signed=1 and the operand MSB is set. The most-negative value negates to itself, and its unsigned reading 2^(WIDTH-1) is correct.
- RUN, each edge:
  - If q[0], acc += h (2·WIDTH-bit add, no overflow possible).
  - h <<= 1, q >>= 1, cnt++.
  - Go to FIX after the iteration where cnt == WIDTH-1.
- FIX: prodt = neg ? -acc : acc; out_valid=1; go to DONE.
- DONE:
  - Hold prodt and out_valid stable.
  - On out_ready, clear out_valid and go to IDLE.
- abort in RUN, FIX or DONE: next state IDLE, out_valid=0, prodt unchanged, no partial result emitted.
- Simultaneous events:
  - abort and start in IDLE: abort wins, start is ignored.
  - start while not ready: ignored, not queued.
  - abort and out_ready in DONE: same result, IDLE.

## Timing
- Edge E0 accepts start. RUN iterations occur at E1..E(WIDTH). FIX registers prodt and out_valid at E(WIDTH+1).
- Latency, start accept to out_valid: WIDTH+1 cycles. Minimum issue interval is WIDTH+3 cycles, with out_ready held high.
- ready is low from the cycle after E0 until the cycle after out_valid is consumed.
- reset_n low at any time, including mid-operation: all outputs take reset values immediately, with no clock required. Release is synchronous to clock.

## Configuration
- SEQ_MULT_ZERO_SKIP_EN defined:
  - In RUN, if q[WIDTH-1:1]==0 during an iteration, that iteration is the last one and the next state is FIX.
  - Latency becomes max(k,0)+2, where k is the index of the highest set bit of |mlier|. mlier=0 gives latency 2.
- Not defined: fixed WIDTH+1 latency, with no early-exit logic.
- The product value is identical in both builds.

## Structure
- Shared package seq_mult_pkg:
  - state typedef (IDLE/RUN/FIX/DONE).
  - CNT_W = $clog2(WIDTH) helper.
  - WIDTH legality check constant.
- One sub-module, mult_twos_neg: parametrised two's-complement negator, ~x+1. Three instances: mlier magnitude, mcand magnitude, result negation.
- Accumulator adder is a plain 2·WIDTH-bit add inside the block.

## Test plan
- WIDTH=32, signed, mlier=-3 (0xFFFFFFFD), mcand=7 -> prodt=0xFFFFFFFF_FFFFFFEB, out_valid exactly 33 cycles after start accept (skip disabled).
- Unsigned, 0xFFFFFFFF × 0xFFFFFFFF -> prodt=0xFFFFFFFE_00000001. The same operands with is_signed=1 -> prodt=1.
- Signed, 0x80000000 × 0x80000000 -> prodt=0x40000000_00000000. Signed, 0x80000000 × 1 -> 0xFFFFFFFF_80000000.
- SEQ_MULT_ZERO_SKIP_EN: mlier=1, mcand=5 -> prodt=5 at latency 2. mlier=0 -> prodt=0 at latency 2. mlier=0x00010000 -> latency 18.
- Hold out_ready low for 5 cycles after out_valid -> prodt and out_valid stable, ready=0, and a start pulse in that window is ignored. Then out_ready=1 -> ready=1 next cycle.
- abort at cycle 10 of RUN -> ready=1 next cycle, out_valid never asserts, prodt keeps its previous value. Separately, reset_n low mid-RUN -> prodt=0, out_valid=0 immediately.
